img_window_reader: RTL and testbench
====================================

Name: img_window_reader

Overview:
- Pipelined frame-buffer reader between the camera frame buffer (RGB565, IMG_W x IMG_H) and the VGA timing generator.
- Places the stored image at a programmable window origin.
- Upscales it 1x/2x/4x by pixel/line replication.
- Converts RGB565 to RGB444; pixels outside the window get a background colour.
- Models the frame-buffer read latency, keeping RGB, DE and the window flag cycle-aligned.

Parameters:
- IMG_W, 160, source image width in pixels
- IMG_H, 120, source image height in lines
- RD_LAT, 1, frame-buffer read latency in clk cycles (1..3)
- BG_RGB, 12'h000, {r,g,b} driven inside DE but outside the window
- ADDR_W, $clog2(IMG_W*IMG_H), address width (derived; do not override)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- DE  in  1  display enable from VGA timing
- x_pixel  in  10  current column
- y_pixel  in  10  current line
- x_org  in  10  window left edge (screen coordinates)
- y_org  in  10  window top edge
- scale  in  2  0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x)
- addr  out  ADDR_W  frame-buffer read address
- rd_en  out  1  read strobe, high when addr is valid
- imgData  in  16  RGB565 read data, valid RD_LAT cycles after rd_en
- r_port, g_port, b_port  out  4 each  colour output
- de_out  out  1  DE delayed to align with colour
- cam_part  out  1  in-window flag aligned with colour

Behaviour:
- Reset (synchronous, active-high): every output and pipeline register = 0; config shadow = {x_org=0, y_org=0, scale=1x}.
- Config latch: x_org, y_org, scale are sampled into shadow registers only on the cycle x_pixel==0 && y_pixel==0. Mid-frame changes take effect on the next frame, so there is no tearing.
- Shift sh = 0/1/2 for 1x/2x/4x. Window width WW = IMG_W<<sh, height WH = IMG_H<<sh.
- Window test: win = DE && x_pixel >= x_sh && x_pixel < x_sh+WW && y_pixel >= y_sh && y_pixel < y_sh+WH.
  - Compare at 11 bits so the sum cannot wrap.
  - A window extending past the screen edge is clipped, never wrapped.
- Stage 0 (registered, 1 cycle after inputs):
  - addr = IMG_W*((y_pixel-y_sh)>>sh) + ((x_pixel-x_sh)>>sh); rd_en = win.
  - When win=0: addr holds its previous value (no 'bz), rd_en=0.
- Delay line: DE and win go through 1+RD_LAT flops.
- Output stage:
  - When the delayed win=1: {r,g,b} = {imgData[15:12], imgData[10:7], imgData[4:1]}.
  - When the delayed DE=1 and win=0: BG_RGB.
  - When the delayed DE=0: 0.
- Total latency, coordinates -> r/g/b/de_out/cam_part: 1+RD_LAT cycles, constant, independent of scale.
- Address range: addr never exceeds IMG_W*IMG_H-1 when rd_en=1. Checked by assertion.
- Reset mid-frame: pipeline flushes to 0. Output resumes correctly once DE/x/y are valid, after 1+RD_LAT cycles.
- Subtraction and shifting operate on 10-bit unsigned values guarded by win. Underflowed values never reach addr while rd_en=1.

Decomposition:
- Shared package (vga_pkg): screen constants H_ACT=640, V_ACT=480, the scale_e enum (SC_1X, SC_2X, SC_4X), and the rgb565_to_444 function.
- One sub-module: pipe_delay (parametrised WIDTH, DEPTH shift register) for the DE/win delay line.
- Address and window logic stay in the top module.

Test Plan:
- scale=1x, org(0,0), RD_LAT=1: pixel (5,2) -> addr=325, rd_en=1 at +1 cycle; imgData=16'hF81F returns RGB=F,0,F and cam_part=1 at +2 cycles.
- scale=2x, org(100,50): pixel (131,61) -> addr=815. Pixels (130,60), (131,60), (130,61) also give 815. Pixel (420,60) -> rd_en=0 and BG_RGB output.
- scale=4x, org(0,0): full frame -> window 640x480. Last visible pixel (639,479) -> addr=19199. No address exceeds 19199.
- Change x_org from 0 to 200 mid-frame (y=100) -> output unchanged until frame end. At next (0,0), pixel (200,0) maps to addr 0.
- RD_LAT=3, DE toggled every line -> de_out equals DE delayed exactly 4 cycles. r/g/b=0 whenever de_out=0.
- Assert reset for 2 cycles mid-line -> all outputs 0 during reset and the cycle after. Correct RGB resumes 1+RD_LAT cycles after reset deasserts.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared screen constants, upscale encoding and colour conversion for the
// VGA display path.
package vga_pkg;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    // Upscale factor. The numeric value is the replication shift.
    typedef enum logic [1:0] {
        SC_1X = 2'd0,
        SC_2X = 2'd1,
        SC_4X = 2'd2
    } scale_e;

    // Map the raw scale code onto a legal factor; the reserved code falls back to 1x.
    function automatic scale_e to_scale(input logic [1:0] code);
        case (code)
            2'd1:    return SC_2X;
            2'd2:    return SC_4X;
            default: return SC_1X;
        endcase
    endfunction

    // Keep the top 4 bits of each RGB565 channel: {r,g,b} as 12 bits.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register used to keep side-band flags aligned with
// frame-buffer read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the flags one stage per clock; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/img_window_reader.sv
// Frame-buffer reader: places the stored RGB565 image at a programmable
// window origin, upscales it by pixel/line replication and emits RGB444
// aligned with a delayed DE and an in-window flag.
module img_window_reader
    import vga_pkg::*;
#(
    parameter int          IMG_W  = 160,
    parameter int          IMG_H  = 120,
    parameter int          RD_LAT = 1,
    parameter logic [11:0] BG_RGB = 12'h000,
    parameter int          ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DE,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic [9:0]        x_org,
    input  logic [9:0]        y_org,
    input  logic [1:0]        scale,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    input  logic [15:0]       imgData,
    output logic [3:0]        r_port,
    output logic [3:0]        g_port,
    output logic [3:0]        b_port,
    output logic              de_out,
    output logic              cam_part
);

    // Configuration shadow registers
    logic [9:0]  x_sh_q, x_sh_d;
    logic [9:0]  y_sh_q, y_sh_d;
    scale_e      scale_q, scale_d;
    logic        cfg_latch;

    // Window geometry and source coordinates
    logic [1:0]  sh;
    logic [10:0] win_w, win_h;
    logic [10:0] x_end, y_end;
    logic        win;
    logic [9:0]  dx, dy;
    logic [9:0]  col, row;
    logic [ADDR_W-1:0] addr_calc;

    // Stage-0 registers
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;

    // Delayed flags and colour
    logic        de_dly;
    logic        win_dly;
    logic [11:0] rgb;

    // The origin/scale only change at the first pixel of a frame, so a frame
    // is always drawn with one consistent configuration.
    assign cfg_latch = (x_pixel == 10'd0) && (y_pixel == 10'd0);

    // Next configuration: the first pixel of the frame already uses the new
    // values so the whole frame is consistent.
    always_comb begin
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        scale_d = scale_q;
        if (cfg_latch) begin
            x_sh_d  = x_org;
            y_sh_d  = y_org;
            scale_d = to_scale(scale);
        end
    end

    // Configuration shadow register.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_sh_q  <= 10'd0;
            y_sh_q  <= 10'd0;
            scale_q <= SC_1X;
        end else begin
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            scale_q <= scale_d;
        end
    end

    assign sh = scale_d;

    // Window test at 11 bits so the far edge never wraps; anything past the
    // screen edge simply never gets scanned, which clips the window.
    always_comb begin
        win_w = 11'(IMG_W) << sh;
        win_h = 11'(IMG_H) << sh;
        x_end = {1'b0, x_sh_d} + win_w;
        y_end = {1'b0, y_sh_d} + win_h;
        win   = DE
              && (x_pixel >= x_sh_d) && ({1'b0, x_pixel} < x_end)
              && (y_pixel >= y_sh_d) && ({1'b0, y_pixel} < y_end);
    end

    // Source pixel address. The subtractions may underflow outside the
    // window, but those values are discarded because win gates the update.
    always_comb begin
        dx        = x_pixel - x_sh_d;
        dy        = y_pixel - y_sh_d;
        col       = dx >> sh;
        row       = dy >> sh;
        addr_calc = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    end

    // Next stage-0 values: the address holds outside the window.
    always_comb begin
        addr_d  = addr_q;
        rd_en_d = win;
        if (win) begin
            addr_d = addr_calc;
        end
    end

    // Stage-0 register: address and read strobe towards the frame buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign addr  = addr_q;
    assign rd_en = rd_en_q;

    // DE and the window flag travel alongside the read: one stage for the
    // address register plus the frame-buffer latency.
    pipe_delay #(
        .WIDTH (2),
        .DEPTH (1 + RD_LAT)
    ) u_flag_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   ({DE, win}),
        .q_o   ({de_dly, win_dly})
    );

    // Output colour: image data inside the window, background elsewhere in
    // the active area, black during blanking.
    always_comb begin
        rgb = 12'h000;
        if (win_dly) begin
            rgb = rgb565_to_444(imgData);
        end else if (de_dly) begin
            rgb = BG_RGB;
        end
    end

    assign r_port   = rgb[11:8];
    assign g_port   = rgb[7:4];
    assign b_port   = rgb[3:0];
    assign de_out   = de_dly;
    assign cam_part = win_dly;

    // A valid read never points outside the stored image.
    a_addr_range: assert property (@(posedge clk)
        rd_en_q |-> (32'(addr_q) < 32'(IMG_W*IMG_H)));

endmodule

// File: tb/tb_img_window_reader.sv
// Randomised bench for img_window_reader: two instances (read latency 1 and 3)
// share the stimulus and are compared against a coordinate-level model.
module tb_img_window_reader;

    localparam int          IMG_W = 160;
    localparam int          IMG_H = 120;
    localparam int          AW    = $clog2(IMG_W*IMG_H);
    localparam logic [11:0] BG    = 12'h5A3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, DE;
    logic [9:0]    x_pixel, y_pixel, x_org, y_org;
    logic [1:0]    scale;
    logic [AW-1:0] addr1, addr3;
    logic          rd1, rd3;
    logic [15:0]   data1, data3;
    logic [3:0]    r1, g1, b1, r3, g3, b3;
    logic          de1, de3, cam1, cam3;

    img_window_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(1), .BG_RGB(BG)) u_lat1 (
        .clk(clk), .reset(reset), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .x_org(x_org), .y_org(y_org), .scale(scale), .addr(addr1), .rd_en(rd1),
        .imgData(data1), .r_port(r1), .g_port(g1), .b_port(b1), .de_out(de1), .cam_part(cam1));

    img_window_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(3), .BG_RGB(BG)) u_lat3 (
        .clk(clk), .reset(reset), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .x_org(x_org), .y_org(y_org), .scale(scale), .addr(addr3), .rd_en(rd3),
        .imgData(data3), .r_port(r3), .g_port(g3), .b_port(b3), .de_out(de3), .cam_part(cam3));

    // Stored image content: an arbitrary hash, with one magenta pixel at 325.
    function automatic logic [15:0] pix(input int a);
        if (a == 325) return 16'hF81F;
        return 16'((a * 40503 + 12345) ^ (a >> 3));
    endfunction

    // RGB565 -> RGB444 by dropping low bits of each channel.
    function automatic logic [11:0] to444(input logic [15:0] p);
        int r, g, b;
        r = (int'(p) >> 11) >> 1;
        g = ((int'(p) >> 5) & 63) >> 2;
        b = (int'(p) & 31) >> 1;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    // Frame-buffer models with 1 and 3 cycles of read latency.
    logic [AW-1:0] fa1_q = '0;
    logic          fv1_q = 1'b0;
    logic [AW-1:0] fa3_q [3];
    logic          fv3_q [3];
    always @(posedge clk) begin
        fa1_q    <= addr1;
        fv1_q    <= rd1;
        fa3_q[0] <= addr3;
        fv3_q[0] <= rd3;
        for (int i = 1; i < 3; i++) begin
            fa3_q[i] <= fa3_q[i-1];
            fv3_q[i] <= fv3_q[i-1];
        end
    end
    assign data1 = fv1_q    ? pix(int'(fa1_q))    : 16'h5A5A;
    assign data3 = fv3_q[2] ? pix(int'(fa3_q[2])) : 16'h5A5A;

    // Reference model state: per-clock-edge history of what the spec says.
    int  n;
    bit  h_rst  [256];
    bit  h_de   [256];
    bit  h_win  [256];
    int  h_addr [256];
    int  m_xs, m_ys, m_sh, m_addr;

    int          e_addr;
    bit          e_rd;
    logic [11:0] e_rgb1, e_rgb3;
    bit          e_de1, e_de3, e_cam1, e_cam3;

    int vectors;
    int miscompares;

    // Expected colour side for an instance whose total latency is 1+lat.
    function automatic void expect_color(input int lat, output logic [11:0] rgb,
                                         output bit de_o, output bit cam);
        int k;
        bit z;
        k    = (n - lat) & 255;
        z    = 1'b0;
        rgb  = 12'h000;
        de_o = 1'b0;
        cam  = 1'b0;
        for (int i = 0; i <= lat; i++) if (h_rst[(n - i) & 255]) z = 1'b1;
        if (!z) begin
            de_o = h_de[k];
            cam  = h_win[k];
            if (cam)       rgb = to444(pix(h_addr[k]));
            else if (de_o) rgb = BG;
        end
    endfunction

    // Apply one pixel for the next clock edge, advance, and compute expectations.
    task automatic tick(input bit de_v, input int xv, input int yv);
        int k, ww, wh;
        bit w;
        DE      = de_v;
        x_pixel = 10'(xv);
        y_pixel = 10'(yv);
        k = (n + 1) & 255;
        if (reset) begin
            m_xs = 0; m_ys = 0; m_sh = 0; m_addr = 0;
            h_rst[k] = 1'b1; h_de[k] = 1'b0; h_win[k] = 1'b0; h_addr[k] = 0;
        end else begin
            if (xv == 0 && yv == 0) begin
                m_xs = int'(x_org);
                m_ys = int'(y_org);
                m_sh = (scale == 2'd1) ? 1 : (scale == 2'd2) ? 2 : 0;
            end
            ww = IMG_W << m_sh;
            wh = IMG_H << m_sh;
            w  = de_v && xv >= m_xs && xv < m_xs + ww && yv >= m_ys && yv < m_ys + wh;
            if (w) m_addr = IMG_W * ((yv - m_ys) >> m_sh) + ((xv - m_xs) >> m_sh);
            h_rst[k] = 1'b0; h_de[k] = de_v; h_win[k] = w; h_addr[k] = m_addr;
        end
        @(negedge clk);
        n      = n + 1;
        e_addr = h_addr[n & 255];
        e_rd   = h_win[n & 255];
        expect_color(1, e_rgb1, e_de1, e_cam1);
        expect_color(3, e_rgb3, e_de3, e_cam3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x_org = 10'd0; y_org = 10'd0; scale = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 5, 5);
            vectors++;
            if ({addr1, rd1, r1, g1, b1, de1, cam1, addr3, rd3, r3, g3, b3, de3, cam3} !== '0) begin
                miscompares++;
                $display("FAIL reset_zero: got addr1=%0d rd1=%0b rgb1=%h de1=%0b cam1=%0b rgb3=%h de3=%0b, expected all zero",
                         addr1, rd1, {r1, g1, b1}, de1, cam1, {r3, g3, b3}, de3);
            end
        end
        $display("txn reset: outputs addr1=%0d rgb1=%h de1=%0b", addr1, {r1, g1, b1}, de1);
        reset = 1'b0;
    endtask

    task automatic test_scale1();
        int xv, yv;
        x_org = 10'd0; y_org = 10'd0; scale = 2'd0;
        tick(1'b1, 0, 0);
        tick(1'b1, 5, 2);
        vectors++;
        if (addr1 !== AW'(325) || rd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL s1_addr: got addr=%0d rd_en=%0b, expected addr=325 rd_en=1", addr1, rd1);
        end
        $display("txn scale1 (5,2): addr=%0d rd_en=%0b", addr1, rd1);
        tick(1'b0, 0, 1);
        vectors++;
        if ({r1, g1, b1, cam1, de1} !== {12'hF0F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL s1_color: got rgb=%h cam=%0b de=%0b, expected rgb=f0f cam=1 de=1", {r1, g1, b1}, cam1, de1);
        end
        $display("txn scale1 (5,2) colour: rgb=%h cam=%0b", {r1, g1, b1}, cam1);
        for (int i = 0; i < 200; i++) begin
            xv = $urandom_range(1, 639);
            yv = $urandom_range(0, 479);
            tick($urandom_range(0, 9) != 0, xv, yv);
            vectors++;
            if ({addr1, rd1, addr3, rd3} !== {AW'(e_addr), e_rd, AW'(e_addr), e_rd}) begin
                miscompares++;
                $display("FAIL s1_rand_addr: got addr1=%0d rd1=%0b addr3=%0d rd3=%0b, expected addr=%0d rd=%0b",
                         addr1, rd1, addr3, rd3, e_addr, e_rd);
            end
            vectors++;
            if ({r1, g1, b1, de1, cam1} !== {e_rgb1, e_de1, e_cam1}) begin
                miscompares++;
                $display("FAIL s1_rand_lat1: got rgb=%h de=%0b cam=%0b, expected rgb=%h de=%0b cam=%0b",
                         {r1, g1, b1}, de1, cam1, e_rgb1, e_de1, e_cam1);
            end
            vectors++;
            if ({r3, g3, b3, de3, cam3} !== {e_rgb3, e_de3, e_cam3}) begin
                miscompares++;
                $display("FAIL s1_rand_lat3: got rgb=%h de=%0b cam=%0b, expected rgb=%h de=%0b cam=%0b",
                         {r3, g3, b3}, de3, cam3, e_rgb3, e_de3, e_cam3);
            end
        end
    endtask

    task automatic test_scale2();
        int xs [4] = '{131, 130, 131, 130};
        int ys [4] = '{61, 60, 60, 61};
        int xv, yv;
        x_org = 10'd100; y_org = 10'd50; scale = 2'd1;
        tick(1'b1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, xs[i], ys[i]);
            vectors++;
            if (addr1 !== AW'(815) || rd1 !== 1'b1) begin
                miscompares++;
                $display("FAIL s2_addr: pixel (%0d,%0d) got addr=%0d rd_en=%0b, expected addr=815 rd_en=1",
                         xs[i], ys[i], addr1, rd1);
            end
            $display("txn scale2 (%0d,%0d): addr=%0d", xs[i], ys[i], addr1);
        end
        tick(1'b1, 420, 60);
        vectors++;
        if (rd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL s2_edge_rd: got rd_en=%0b, expected 0", rd1);
        end
        tick(1'b1, 1, 1);
        vectors++;
        if ({r1, g1, b1, de1, cam1} !== {BG, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL s2_edge_bg: got rgb=%h de=%0b cam=%0b, expected rgb=%h de=1 cam=0", {r1, g1, b1}, de1, cam1, BG);
        end
        $display("txn scale2 (420,60): rgb=%h cam=%0b", {r1, g1, b1}, cam1);
        for (int i = 0; i < 200; i++) begin
            xv = $urandom_range(60, 470);
            yv = $urandom_range(20, 310);
            tick($urandom_range(0, 9) != 0, xv, yv);
            vectors++;
            if ({addr1, rd1, addr3, rd3} !== {AW'(e_addr), e_rd, AW'(e_addr), e_rd}) begin
                miscompares++;
                $display("FAIL s2_rand_addr: got addr1=%0d rd1=%0b addr3=%0d rd3=%0b, expected addr=%0d rd=%0b",
                         addr1, rd1, addr3, rd3, e_addr, e_rd);
            end
            vectors++;
            if ({r1, g1, b1, de1, cam1, r3, g3, b3, de3, cam3} !== {e_rgb1, e_de1, e_cam1, e_rgb3, e_de3, e_cam3}) begin
                miscompares++;
                $display("FAIL s2_rand_color: got rgb1=%h de1=%0b cam1=%0b rgb3=%h de3=%0b cam3=%0b, expected %h %0b %0b / %h %0b %0b",
                         {r1, g1, b1}, de1, cam1, {r3, g3, b3}, de3, cam3, e_rgb1, e_de1, e_cam1, e_rgb3, e_de3, e_cam3);
            end
        end
    endtask

    task automatic test_scale4();
        int xv, yv;
        x_org = 10'd0; y_org = 10'd0; scale = 2'd2;
        tick(1'b1, 0, 0);
        tick(1'b1, 639, 479);
        vectors++;
        if (addr1 !== AW'(19199) || rd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL s4_last: got addr=%0d rd_en=%0b, expected addr=19199 rd_en=1", addr1, rd1);
        end
        $display("txn scale4 (639,479): addr=%0d", addr1);
        for (int i = 0; i < 200; i++) begin
            xv = $urandom_range(1, 639);
            yv = $urandom_range(0, 479);
            if (i % 8 == 0) begin xv = 636 + (i % 4); yv = 476 + ((i / 4) % 4); end
            tick(1'b1, xv, yv);
            vectors++;
            if (rd1 === 1'b1 && int'(addr1) > 19199) begin
                miscompares++;
                $display("FAIL s4_range: got addr=%0d, expected at most 19199", addr1);
            end
            vectors++;
            if ({addr1, rd1, r1, g1, b1, cam1} !== {AW'(e_addr), e_rd, e_rgb1, e_cam1}) begin
                miscompares++;
                $display("FAIL s4_rand: got addr=%0d rd=%0b rgb=%h cam=%0b, expected addr=%0d rd=%0b rgb=%h cam=%0b",
                         addr1, rd1, {r1, g1, b1}, cam1, e_addr, e_rd, e_rgb1, e_cam1);
            end
        end
    endtask

    task automatic test_cfg_latch();
        x_org = 10'd0; y_org = 10'd0; scale = 2'd0;
        tick(1'b1, 0, 0);
        x_org = 10'd200;
        tick(1'b1, 5, 100);
        vectors++;
        if (addr1 !== AW'(16005) || rd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_hold: got addr=%0d rd_en=%0b, expected addr=16005 rd_en=1", addr1, rd1);
        end
        $display("txn cfg mid-frame (5,100): addr=%0d", addr1);
        tick(1'b1, 300, 100);
        vectors++;
        if (rd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_hold_out: got rd_en=%0b, expected 0", rd1);
        end
        tick(1'b1, 0, 0);
        tick(1'b1, 200, 0);
        vectors++;
        if (addr1 !== AW'(0) || rd1 !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_new_frame: got addr=%0d rd_en=%0b, expected addr=0 rd_en=1", addr1, rd1);
        end
        $display("txn cfg next frame (200,0): addr=%0d rd_en=%0b", addr1, rd1);
        tick(1'b1, 199, 0);
        vectors++;
        if (rd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_left_edge: got rd_en=%0b, expected 0", rd1);
        end
    endtask

    task automatic test_latency3();
        bit de_log [$];
        bit de_v;
        int seg;
        x_org = 10'd40; y_org = 10'd30; scale = 2'd1;
        tick(1'b1, 0, 0);
        de_v = 1'b1;
        seg  = 0;
        for (int i = 0; i < 240; i++) begin
            if (seg == 0) begin de_v = !de_v; seg = $urandom_range(2, 9); end
            seg--;
            tick(de_v, $urandom_range(1, 639), $urandom_range(0, 479));
            de_log.push_back(de_v);
            if (de_log.size() >= 4) begin
                vectors++;
                if (de3 !== de_log[de_log.size() - 4]) begin
                    miscompares++;
                    $display("FAIL lat3_de: got de_out=%0b, expected %0b", de3, de_log[de_log.size() - 4]);
                end
                if (de3 === 1'b0) begin
                    vectors++;
                    if ({r3, g3, b3} !== 12'h000) begin
                        miscompares++;
                        $display("FAIL lat3_blank: got rgb=%h, expected 000", {r3, g3, b3});
                    end
                end
            end
        end
        $display("txn latency3: %0d DE samples tracked", de_log.size());
    endtask

    task automatic test_reset_mid();
        x_org = 10'd0; y_org = 10'd0; scale = 2'd0;
        tick(1'b1, 0, 0);
        for (int i = 0; i < 12; i++) tick(1'b1, $urandom_range(1, 159), $urandom_range(1, 119));
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 10 + i, 10);
            vectors++;
            if ({addr1, rd1, r1, g1, b1, de1, cam1, addr3, rd3, r3, g3, b3, de3, cam3} !== '0) begin
                miscompares++;
                $display("FAIL rst_mid: got addr1=%0d rd1=%0b rgb1=%h de1=%0b rgb3=%h de3=%0b, expected all zero",
                         addr1, rd1, {r1, g1, b1}, de1, {r3, g3, b3}, de3);
            end
        end
        reset = 1'b0;
        tick(1'b1, 12, 10);
        vectors++;
        if ({r1, g1, b1, de1, cam1, r3, g3, b3, de3, cam3} !== '0) begin
            miscompares++;
            $display("FAIL rst_after: got rgb1=%h de1=%0b rgb3=%h de3=%0b, expected all zero",
                     {r1, g1, b1}, de1, {r3, g3, b3}, de3);
        end
        $display("txn reset mid-line: rgb1=%h de1=%0b after release", {r1, g1, b1}, de1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 13 + i, 10);
            vectors++;
            if ({addr1, rd1, r1, g1, b1, de1, cam1, r3, g3, b3, de3, cam3} !==
                {AW'(e_addr), e_rd, e_rgb1, e_de1, e_cam1, e_rgb3, e_de3, e_cam3}) begin
                miscompares++;
                $display("FAIL rst_resume: got addr=%0d rgb1=%h de1=%0b rgb3=%h de3=%0b, expected addr=%0d rgb1=%h de1=%0b rgb3=%h de3=%0b",
                         addr1, {r1, g1, b1}, de1, {r3, g3, b3}, de3, e_addr, e_rgb1, e_de1, e_rgb3, e_de3);
            end
        end
    endtask

    task automatic test_random_cfg();
        for (int f = 0; f < 6; f++) begin
            x_org = 10'($urandom_range(0, 700));
            y_org = 10'($urandom_range(0, 500));
            scale = 2'($urandom_range(0, 3));
            tick(1'b1, 0, 0);
            $display("txn frame org=(%0d,%0d) scale=%0d", x_org, y_org, scale);
            for (int i = 0; i < 150; i++) begin
                tick($urandom_range(0, 9) != 0, $urandom_range(1, 639), $urandom_range(0, 479));
                vectors++;
                if ({addr1, rd1, addr3, rd3} !== {AW'(e_addr), e_rd, AW'(e_addr), e_rd}) begin
                    miscompares++;
                    $display("FAIL cfg_rand_addr: got addr1=%0d rd1=%0b addr3=%0d rd3=%0b, expected addr=%0d rd=%0b",
                             addr1, rd1, addr3, rd3, e_addr, e_rd);
                end
                vectors++;
                if ({r1, g1, b1, de1, cam1, r3, g3, b3, de3, cam3} !== {e_rgb1, e_de1, e_cam1, e_rgb3, e_de3, e_cam3}) begin
                    miscompares++;
                    $display("FAIL cfg_rand_color: got rgb1=%h de1=%0b cam1=%0b rgb3=%h de3=%0b cam3=%0b, expected %h %0b %0b / %h %0b %0b",
                             {r1, g1, b1}, de1, cam1, {r3, g3, b3}, de3, cam3, e_rgb1, e_de1, e_cam1, e_rgb3, e_de3, e_cam3);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n           = 0;
        m_xs = 0; m_ys = 0; m_sh = 0; m_addr = 0;
        for (int i = 0; i < 256; i++) begin
            h_rst[i] = 1'b1; h_de[i] = 1'b0; h_win[i] = 1'b0; h_addr[i] = 0;
        end
        reset   = 1'b1;
        DE      = 1'b0;
        x_pixel = 10'd0; y_pixel = 10'd0;
        x_org   = 10'd0; y_org   = 10'd0;
        scale   = 2'd0;
        @(negedge clk);
        test_reset();
        test_scale1();
        test_scale2();
        test_scale4();
        test_cfg_latch();
        test_latency3();
        test_reset_mid();
        test_random_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
